regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
Register bank shared between two masters.
- Port A is the I2C slave register interface. It has fixed priority, never stalls and reads combinationally.
- Port B is a req/ack fabric master, e.g. a host FSM or SPI bridge. It is sequenced through a small FSM that defers to A's writes.
- The block owns the storage and exports every register to the fabric as a flat bus.

Parameters:
NUM_REGS, 16, number of 8-bit registers (4..256)
ID_VALUE, 8'hA5, read-only contents of register 0
MAX_STALL, 4, consecutive stall cycles after which a B access aborts with error

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous, active-low reset
a_addr  in  8  port A register address
a_wdata  in  8  port A write data
a_wr  in  1  port A single-cycle write strobe
a_rd  in  1  port A single-cycle read strobe (side effects only)
a_rdata  out  8  port A read data, combinational from a_addr
b_req  in  1  port B request, sampled only in B_IDLE
b_wr  in  1  port B 1=write, 0=read, sampled with b_req
b_addr  in  8  port B address, sampled with b_req
b_wdata  in  8  port B write data, sampled with b_req
b_ack  out  1  one-cycle completion pulse
b_err  out  1  valid with b_ack; 1 = aborted or illegal access
b_rdata  out  8  registered read data, valid with b_ack
reg_q  out  NUM_REGS*8  all register contents; reg n at bits [8n+7:8n]

Behaviour:
- Reset (rst_n low, async):
  - reg0 = ID_VALUE; all other regs = 0.
  - B FSM = B_IDLE; b_ack = 0, b_err = 0, b_rdata = 0; stall counter = 0.
- Register map:
  - reg0 is read-only (ID).
  - reg1 is read-only STATUS: bit0 = B FSM not in B_IDLE; [7:1] = 0, or the conflict count when ARB_STATS_EN is defined.
  - regs 2..NUM_REGS-1 are read/write.
  - Address >= NUM_REGS: reads return 8'h00, writes are ignored.
- Port A:
  - a_rdata = reg[a_addr] combinationally, zero latency. This is required because the I2C slave loads tx data in the same cycle it drives the address.
  - a_wr commits at the clock edge of the strobe cycle. It is never blocked.
  - Writes to reg0, reg1 or out-of-range addresses are dropped silently.
- Port B FSM:
  - B_IDLE: on b_req=1, latch b_wr/b_addr/b_wdata; clear stall counter; go to B_PEND.
  - B_PEND, a_wr=1 this cycle (conflict): no B access; stall counter +1.
    - If the counter reaches MAX_STALL, go to B_ACK with err=1 and no write.
  - B_PEND, a_wr=0, write:
    - Commit to a RW address and go to B_ACK with err=0.
    - Address is RO or out of range: no commit, go to B_ACK with err=1.
  - B_PEND, a_wr=0, read: b_rdata <= reg[latched addr] (0 and err=1 if out of range); go to B_ACK.
  - B_ACK: b_ack=1 for exactly one cycle; b_err and b_rdata are held valid; return to B_IDLE.
- Latency: request in cycle N, commit in N+1, b_ack in N+2 when there is no conflict. Each conflict cycle adds one cycle.
- b_req is ignored outside B_IDLE. If b_req is still high in the B_IDLE cycle after b_ack, it starts a new request.
- b_rdata holds its last value between acks.
- Simultaneous events:
  - A and B commit never occur in the same cycle; B always yields.
  - A B read of an address being written by A stalls, so B returns the new value.
  - An A read in the cycle B commits a write returns the old value; the new value appears next cycle.
- Counter widths: the stall counter saturates at MAX_STALL. The conflict counter wraps modulo 128.
- Reset mid-operation: a pending B access is discarded with no write and no ack.

Optional Feature:
Macro ARB_STATS_EN.
- Defined:
  - STATUS[7:1] counts B_PEND conflict cycles, wrapping at 127.
  - It clears in the cycle a_rd=1 with a_addr=1. If a conflict occurs in that same cycle, the count becomes 1.
- Not defined: STATUS[7:1] = 0; no counter logic is generated.

Test Plan:
- Reset, then a_addr=0 → a_rdata=8'hA5; reg_q all zero except [7:0]=8'hA5; b_ack=0.
- a_wr addr 3 data 8'h5C → a_rdata at addr 3 = 8'h5C next cycle; reg_q[31:24]=8'h5C.
- B write addr 4 data 8'h77 with no A activity → b_ack in cycle N+2, b_err=0, reg4=8'h77; B read addr 4 → b_rdata=8'h77.
- B read addr 5 while A writes 8'h33 to addr 5 in the B_PEND cycle → one stall, b_ack at N+3, b_rdata=8'h33; STATUS[7:1]=1 with ARB_STATS_EN.
- Hold a_wr high for 6 cycles with B pending (MAX_STALL=4) → b_ack with b_err=1; B write not committed; all A writes committed.
- B write to addr 0 and to addr 8'hF0 → b_err=1 each, reg0 stays 8'hA5; assert rst_n low during B_PEND → no ack, regs reset.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// Bus bundle for regfile_arbiter: port A (I2C slave registers)
// and port B (req/ack fabric master) signals with master/slave views.
interface regfile_arbiter_if;
  logic [7:0] a_addr;
  logic [7:0] a_wdata;
  logic       a_wr;
  logic       a_rd;
  logic [7:0] a_rdata;
  logic       b_req;
  logic       b_wr;
  logic [7:0] b_addr;
  logic [7:0] b_wdata;
  logic       b_ack;
  logic       b_err;
  logic [7:0] b_rdata;

  modport master (
    output a_addr, a_wdata, a_wr, a_rd,
    output b_req, b_wr, b_addr, b_wdata,
    input  a_rdata, b_ack, b_err, b_rdata
  );

  modport slave (
    input  a_addr, a_wdata, a_wr, a_rd,
    input  b_req, b_wr, b_addr, b_wdata,
    output a_rdata, b_ack, b_err, b_rdata
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Register bank shared by port A (fixed priority, comb read) and port B
// (req/ack FSM that yields to A writes). Ports: clk, rst_n, bus (slave),
// reg_q (flat dump, reg n at [8n+7:8n]). Optional macro: ARB_STATS_EN.
module regfile_arbiter #(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] ID_VALUE  = 8'hA5,
  parameter int         MAX_STALL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_arbiter_if.slave      bus,
  output logic [NUM_REGS*8-1:0] reg_q
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SW = $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(MAX_STALL);
  localparam logic [8:0] NREG9 = 9'(NUM_REGS);

  typedef enum logic [1:0] {
    B_IDLE,
    B_PEND,
    B_ACK
  } b_state_e;

  b_state_e state;
  b_state_e state_nxt;

  logic          l_wr;
  logic [7:0]    l_addr;
  logic [7:0]    l_wdata;
  logic [7:0]    l_rd;
  logic [SW-1:0] stall_q;
  logic [SW-1:0] stall_inc;
  logic [7:0]    mem [NUM_REGS];
  logic [6:0]    conf_q;
  logic [7:0]    status;
  logic          conflict;
  logic          b_commit;
  logic          b_read;
  logic          b_err_q;
  logic [7:0]    b_rdata_q;
  logic          wr_en;
  logic [7:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          a_ok;
  logic          l_ok;

  function automatic logic in_range(input logic [7:0] a);
    return {1'b0, a} < NREG9;
  endfunction

  function automatic logic is_rw(input logic [7:0] a);
    return in_range(a) && (a >= 8'd2);
  endfunction

  assign a_ok      = in_range(bus.a_addr);
  assign l_ok      = in_range(l_addr);
  assign stall_inc = stall_q + SW'(1);
  assign status    = {conf_q, state != B_IDLE};

  // Zero-latency read: the I2C slave loads tx data in the
  // same cycle it presents the address.
  always_comb begin
    bus.a_rdata = 8'h00;
    unique case (1'b1)
      a_ok && bus.a_addr == 8'd0: bus.a_rdata = ID_VALUE;
      a_ok && bus.a_addr == 8'd1: bus.a_rdata = status;
      a_ok && bus.a_addr > 8'd1:
        bus.a_rdata = mem[bus.a_addr[AW-1:0]];
      default: ;
    endcase
  end

  always_comb begin
    l_rd = 8'h00;
    unique case (1'b1)
      l_ok && l_addr == 8'd0: l_rd = ID_VALUE;
      l_ok && l_addr == 8'd1: l_rd = status;
      l_ok && l_addr > 8'd1:  l_rd = mem[l_addr[AW-1:0]];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= B_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      B_IDLE: if (bus.b_req) state_nxt = B_PEND;
      B_PEND: begin
        if (!bus.a_wr)                   state_nxt = B_ACK;
        else if (stall_inc == STALL_LIM) state_nxt = B_ACK;
      end
      B_ACK:   state_nxt = B_IDLE;
      default: state_nxt = B_IDLE;
    endcase
  end

  always_comb begin
    bus.b_ack = (state == B_ACK);
    conflict  = (state == B_PEND) && bus.a_wr;
    b_commit  = (state == B_PEND) && !bus.a_wr
                && l_wr && is_rw(l_addr);
    b_read    = (state == B_PEND) && !bus.a_wr && !l_wr;
  end

  assign bus.b_err   = b_err_q;
  assign bus.b_rdata = b_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_wr      <= 1'b0;
      l_addr    <= 8'h00;
      l_wdata   <= 8'h00;
      stall_q   <= '0;
      b_err_q   <= 1'b0;
      b_rdata_q <= 8'h00;
    end else begin
      if (state == B_IDLE && bus.b_req) begin
        l_wr    <= bus.b_wr;
        l_addr  <= bus.b_addr;
        l_wdata <= bus.b_wdata;
        stall_q <= '0;
      end
      if (conflict && stall_q != STALL_LIM) stall_q <= stall_inc;
      if (conflict && stall_inc == STALL_LIM) b_err_q <= 1'b1;
      if (state == B_PEND && !bus.a_wr) begin
        if (l_wr) begin
          b_err_q <= !is_rw(l_addr);
        end else begin
          b_err_q <= !l_ok;
        end
      end
      if (b_read) b_rdata_q <= l_rd;
    end
  end

  // A has priority; b_commit already excludes a_wr cycles.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    if (bus.a_wr && is_rw(bus.a_addr)) begin
      wr_en   = 1'b1;
      wr_addr = bus.a_addr;
      wr_data = bus.a_wdata;
    end else if (b_commit) begin
      wr_en   = 1'b1;
      wr_addr = l_addr;
      wr_data = l_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= 8'h00;
    end else begin
      for (int i = 2; i < NUM_REGS; i++) begin
        if (wr_en && wr_addr == 8'(i)) mem[i] <= wr_data;
      end
    end
  end

`ifdef ARB_STATS_EN
  // A status read and a conflict in the same cycle leave a count of 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conf_q <= 7'd0;
    end else if (bus.a_rd && bus.a_addr == 8'd1) begin
      conf_q <= conflict ? 7'd1 : 7'd0;
    end else if (conflict) begin
      conf_q <= conf_q + 7'd1;
    end
  end
`else
  logic unused_a_rd;
  assign unused_a_rd = bus.a_rd;
  assign conf_q      = 7'd0;
`endif

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_q
    if (n == 0) begin : g_id
      assign reg_q[8*n +: 8] = ID_VALUE;
    end else if (n == 1) begin : g_st
      assign reg_q[8*n +: 8] = status;
    end else begin : g_rw
      assign reg_q[8*n +: 8] = mem[n];
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized bench for regfile_arbiter against a transaction-level
// model of the register map and B-port timing rules.
module tb_regfile_arbiter;
  localparam int NR = 16;
  localparam int MS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR*8-1:0] reg_q;

  always #5 clk = ~clk;

  regfile_arbiter_if bus ();

  regfile_arbiter #(
    .NUM_REGS (NR),
    .ID_VALUE (8'hA5),
    .MAX_STALL(MS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .reg_q(reg_q)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] mreg [NR];
  int         conf;
  logic [7:0] exp_rdata;

  bit         p_wr   [32];
  bit         p_rd   [32];
  logic [7:0] p_addr [32];
  logic [7:0] p_data [32];
  int         plen;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] m_read(input int a, input bit busy);
    if (a >= NR) return 8'h00;
    if (a == 0) return 8'hA5;
`ifdef ARB_STATS_EN
    if (a == 1) return {7'(conf), busy};
`else
    if (a == 1) return {7'd0, busy};
`endif
    return mreg[a];
  endfunction

  function automatic logic [127:0] m_q(input bit busy);
    logic [127:0] q = '0;
    for (int i = 0; i < NR; i++) q[8*i +: 8] = m_read(i, busy);
    return q;
  endfunction

  function automatic bit m_rw(input int a);
    return a >= 2 && a < NR;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) mreg[i] = 8'h00;
    conf = 0;
    exp_rdata = 8'h00;
  endtask

  task automatic m_cycle(input bit wr, input bit rd,
                         input logic [7:0] addr,
                         input logic [7:0] data, input bit cf);
    if (rd && addr == 8'd1) conf = cf ? 1 : 0;
    else if (cf) conf = (conf + 1) % 128;
    if (wr && m_rw(addr)) mreg[addr] = data;
  endtask

  task automatic clear_pat();
    for (int i = 0; i < 32; i++) begin
      p_wr[i] = 0;
      p_rd[i] = 0;
      p_addr[i] = 8'h00;
      p_data[i] = 8'h00;
    end
    plen = 1;
  endtask

  task automatic idle_cycle(input bit wr, input bit rd,
                            input logic [7:0] addr,
                            input logic [7:0] data);
    @(negedge clk);
    bus.a_wr = wr;
    bus.a_rd = rd;
    bus.a_addr = addr;
    bus.a_wdata = data;
    bus.b_req = 1'b0;
    #1;
    check("idle_a_rdata", bus.a_rdata, m_read(addr, 0));
    check("idle_b_ack", bus.b_ack, 0);
    check("idle_reg_q", reg_q, m_q(0));
    m_cycle(wr, rd, addr, data, 0);
  endtask

  // Cycle 0 raises b_req; p_* give A activity per cycle offset.
  task automatic run_b(input bit wr, input logic [7:0] addr,
                       input logic [7:0] data);
    int k = 0;
    int ack_i, commit_i, n;
    bit abort, exp_err, busy, cf;
    while (k < MS && p_wr[k+1]) k++;
    abort = (k >= MS);
    ack_i = abort ? 1 + MS : 2 + k;
    commit_i = abort ? -1 : 1 + k;
    if (abort) exp_err = 1;
    else if (wr) exp_err = !m_rw(addr);
    else exp_err = !(addr < NR);
    n = (ack_i + 1 > plen) ? ack_i + 1 : plen;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.a_wr = p_wr[i];
      bus.a_rd = p_rd[i];
      bus.a_addr = p_addr[i];
      bus.a_wdata = p_data[i];
      bus.b_req = (i == 0);
      bus.b_wr = wr;
      bus.b_addr = addr;
      bus.b_wdata = data;
      #1;
      busy = (i >= 1 && i <= ack_i);
      check("a_rdata", bus.a_rdata, m_read(p_addr[i], busy));
      if (i == commit_i && !wr) exp_rdata = m_read(addr, 1);
      check("b_ack", bus.b_ack, i == ack_i);
      if (i == ack_i) begin
        check("b_err", bus.b_err, exp_err);
        check("b_rdata", bus.b_rdata, exp_rdata);
      end
      cf = (i >= 1 && i < ack_i && p_wr[i]);
      m_cycle(p_wr[i], p_rd[i], p_addr[i], p_data[i], cf);
      if (i == commit_i && wr && m_rw(addr)) mreg[addr] = data;
    end
    bus.b_req = 1'b0;
  endtask

  initial begin
    bus.a_addr = 8'h00;
    bus.a_wdata = 8'h00;
    bus.a_wr = 1'b0;
    bus.a_rd = 1'b0;
    bus.b_req = 1'b0;
    bus.b_wr = 1'b0;
    bus.b_addr = 8'h00;
    bus.b_wdata = 8'h00;
    m_reset();
    clear_pat();

    repeat (2) @(negedge clk);
    #1;
    check("rst_a_rdata", bus.a_rdata, 8'hA5);
    check("rst_reg_q", reg_q, m_q(0));
    check("rst_b_ack", bus.b_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;

    idle_cycle(1, 0, 8'd3, 8'h5C);
    idle_cycle(0, 0, 8'd3, 8'h00);
    check("reg3_q", reg_q[31:24], 8'h5C);

    clear_pat();
    run_b(1, 8'd4, 8'h77);
    idle_cycle(0, 0, 8'd4, 8'h00);
    clear_pat();
    run_b(0, 8'd4, 8'h00);
    check("b_read4", bus.b_rdata, 8'h77);

    clear_pat();
    plen = 2;
    p_wr[1] = 1;
    p_addr[1] = 8'd5;
    p_data[1] = 8'h33;
    run_b(0, 8'd5, 8'h00);
    check("b_read5", bus.b_rdata, 8'h33);
    idle_cycle(0, 1, 8'd1, 8'h00);

    clear_pat();
    plen = 7;
    for (int i = 1; i <= 6; i++) begin
      p_wr[i] = 1;
      p_addr[i] = 8'(5 + i);
      p_data[i] = 8'(8'h10 * i);
    end
    run_b(1, 8'd12, 8'hEE);
    idle_cycle(0, 0, 8'd12, 8'h00);

    clear_pat();
    run_b(1, 8'd0, 8'h11);
    clear_pat();
    run_b(1, 8'hF0, 8'h22);
    idle_cycle(0, 0, 8'd0, 8'h00);

    @(negedge clk);
    bus.b_req = 1'b1;
    bus.b_wr = 1'b1;
    bus.b_addr = 8'd6;
    bus.b_wdata = 8'h99;
    @(negedge clk);
    bus.b_req = 1'b0;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("midrst_reg_q", reg_q, m_q(0));
    check("midrst_b_ack", bus.b_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle_cycle(0, 0, 8'd6, 8'h00);

    for (int t = 0; t < 150; t++) begin
      bit all1;
      logic [7:0] ba;
      clear_pat();
      all1 = ($urandom_range(0, 5) == 0);
      plen = all1 ? MS + 2 + $urandom_range(0, 2)
                  : $urandom_range(1, 8);
      for (int i = 0; i < plen; i++) begin
        p_wr[i] = all1 ? (i > 0) : 1'($urandom_range(0, 1));
        p_rd[i] = 1'($urandom_range(0, 1));
        p_addr[i] = 8'($urandom_range(0, 17));
        p_data[i] = 8'($urandom);
      end
      ba = ($urandom_range(0, 7) == 0) ? 8'hF0
                                       : 8'($urandom_range(0, 17));
      run_b(1'($urandom_range(0, 1)), ba, 8'($urandom));
      repeat ($urandom_range(1, 2))
        idle_cycle(1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 17)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
